// File: rtl/dht11_poll_ctrl.sv
// DHT11 measurement scheduler: paces transceiver reads, enforces the sensor's
// minimum inter-read gap, validates checksums, retries, and holds the last good reading.
module dht11_poll_ctrl #(
  parameter int unsigned PERIOD_CYC  = 250_000_000,
  parameter int unsigned GAP_CYC     = 137_500_000,
  parameter int unsigned RESP_TO_CYC = 3_750_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CNT_W       = 28
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        force_req,
  output logic        start,
  input  logic        xcvr_busy,
  input  logic        xcvr_done,
  input  logic        xcvr_err,
  input  logic [39:0] frame,
  output logic [7:0]  humidity,
  output logic [7:0]  temperature,
  output logic        data_valid,
  output logic        update,
  output logic [7:0]  err_cnt,
  output logic        ctrl_busy,
  output logic [2:0]  state_dbg
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0]   GAP_MAX     = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0]   PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0]   RESP_LAST   = CNT_W'(RESP_TO_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_GAP  = 3'd1,
    S_START     = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_CHECK     = 3'd4,
    S_FAIL      = 3'd5,
    S_POLL_WAIT = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   tmr_q;
  logic [RETRY_W-1:0] retry_q;
  logic [39:0]        frame_q;
  logic [7:0]         sum;
  logic               sum_ok;

  // Byte sum wraps naturally in 8 bits, which is exactly the DHT11 checksum rule.
  assign sum       = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  assign sum_ok    = (sum == frame_q[7:0]);
  assign gap_cnt_d = (gap_cnt_q >= GAP_MAX) ? GAP_MAX : gap_cnt_q + CNT_W'(1);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_WAIT_GAP;
      S_WAIT_GAP: begin
        if (!enable)                                  state_d = S_IDLE;
        else if ((gap_cnt_q >= GAP_MAX) && !xcvr_busy) state_d = S_START;
      end
      S_START:     state_d = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (xcvr_done)                            state_d = S_CHECK;
        else if (xcvr_err || (tmr_q == RESP_LAST)) state_d = S_FAIL;
      end
      S_CHECK:     state_d = sum_ok ? S_POLL_WAIT : S_FAIL;
      S_FAIL:      state_d = (retry_q < RETRY_MAX) ? S_WAIT_GAP : S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (!enable)                                state_d = S_IDLE;
        else if (force_req || (tmr_q == PERIOD_LAST)) state_d = S_WAIT_GAP;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= '0;
      tmr_q       <= '0;
      retry_q     <= '0;
      frame_q     <= '0;
      start       <= 1'b0;
      update      <= 1'b0;
      humidity    <= '0;
      temperature <= '0;
      data_valid  <= 1'b0;
      err_cnt     <= '0;
      ctrl_busy   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= (state_d == S_START) ? '0 : gap_cnt_d;
      start     <= (state_d == S_START);
      ctrl_busy <= (state_d == S_START) || (state_d == S_WAIT_RESP) || (state_d == S_CHECK);
      update    <= 1'b0;

      case (state_q)
        S_START:     tmr_q <= '0;
        S_WAIT_RESP: begin
          tmr_q <= tmr_q + CNT_W'(1);
          if (xcvr_done) frame_q <= frame;
        end
        S_CHECK: begin
          if (sum_ok) begin
            humidity    <= frame_q[39:32];
            temperature <= frame_q[23:16];
            data_valid  <= 1'b1;
            update      <= 1'b1;
            retry_q     <= '0;
          end
        end
        S_FAIL: begin
          if (retry_q < RETRY_MAX) begin
            retry_q <= retry_q + RETRY_W'(1);
          end else begin
            retry_q    <= '0;
            data_valid <= 1'b0;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        S_POLL_WAIT: tmr_q <= tmr_q + CNT_W'(1);
        default: ;
      endcase

      // Entering POLL_WAIT restarts the period timer from zero.
      if ((state_d == S_POLL_WAIT) && (state_q != S_POLL_WAIT)) tmr_q <= '0;
    end
  end

endmodule

// File: doc/dht11_poll_ctrl.md
Name: dht11_poll_ctrl

Overview:
- Measurement scheduler for the DHT11 sensor path.
- Decides when the DHT11 single-wire transceiver runs a read and enforces the sensor's minimum inter-read gap.
- Validates the checksum of each returned 40-bit frame, retries failed reads, and holds the last good humidity/temperature for the BCD/FND display chain.
- Sits between the top level (enable, force request) and the transceiver (start/busy/done/err handshake).

Parameters:
- PERIOD_CYC, 250_000_000, idle cycles in POLL_WAIT between measurement rounds (2 s at 125 MHz).
- GAP_CYC, 137_500_000, minimum cycles from one start pulse to the next start (1.1 s).
- RESP_TO_CYC, 3_750_000, watchdog on the transceiver response (30 ms).
- MAX_RETRY, 3, extra attempts after a failed read before the round is declared failed.
- CNT_W, 28, width of gap_cnt and tmr; must hold max(PERIOD_CYC, GAP_CYC, RESP_TO_CYC).

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- enable, in, 1, level; polling runs while high.
- force_req, in, 1, pulse; request an immediate read (still gap-limited).
- start, out, 1, one-cycle pulse to the transceiver.
- xcvr_busy, in, 1, transceiver owns the bus.
- xcvr_done, in, 1, one-cycle pulse; frame valid in the same cycle.
- xcvr_err, in, 1, one-cycle pulse; bus protocol error or timeout.
- frame, in, 40, {hum_int, hum_dec, temp_int, temp_dec, checksum}.
- humidity, out, 8, last good hum_int.
- temperature, out, 8, last good temp_int.
- data_valid, out, 1, high while the last round succeeded.
- update, out, 1, one-cycle pulse when humidity/temperature are reloaded.
- err_cnt, out, 8, failed rounds; saturates at 255.
- ctrl_busy, out, 1, high in START, WAIT_RESP, CHECK.
- state_dbg, out, 3, state encoding for the LED bar.

Behaviour:
- Reset (async on reset_n low):
  - State IDLE; all outputs 0.
  - gap_cnt = 0, tmr = 0, retry = 0.
- gap_cnt: +1 every cycle, saturating at GAP_CYC. Cleared on the edge that enters START.
- States (state_dbg value):
  - IDLE (0): enable=1 -> WAIT_GAP.
  - WAIT_GAP (1): enable=0 -> IDLE. If gap_cnt >= GAP_CYC and xcvr_busy=0 -> START; otherwise hold.
  - START (2): start=1 for exactly this cycle; load tmr=0; -> WAIT_RESP.
  - WAIT_RESP (3): tmr +1 per cycle. Priority within a cycle: xcvr_done > xcvr_err > watchdog (tmr == RESP_TO_CYC-1).
    - xcvr_done -> capture frame, go CHECK.
    - xcvr_err or watchdog -> FAIL.
    - enable=0 is ignored here; the transaction is never aborted.
  - CHECK (4): one cycle. sum = (frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8]) mod 256.
    - sum == frame[7:0] -> load humidity = frame[39:32], temperature = frame[23:16]; data_valid=1; update=1 (one cycle); retry=0; go POLL_WAIT.
    - Mismatch -> FAIL.
  - FAIL (5): one cycle.
    - retry < MAX_RETRY -> retry+1, go WAIT_GAP.
    - Else -> retry=0, data_valid=0, err_cnt+1 (saturating), go POLL_WAIT.
    - humidity/temperature are held, never cleared.
  - POLL_WAIT (6): tmr cleared on entry, then +1 per cycle.
    - enable=0 -> IDLE.
    - force_req=1 -> WAIT_GAP.
    - tmr == PERIOD_CYC-1 -> WAIT_GAP.
- force_req in IDLE with enable=1, or in WAIT_GAP: no extra effect. force_req in START, WAIT_RESP, CHECK, FAIL: dropped, not queued.
- enable deasserted mid-transaction: the round finishes through CHECK/FAIL. The following POLL_WAIT or WAIT_GAP exits to IDLE.
- Outputs are registered. start rises on the edge that enters START.
- First start after reset with enable=1: start high after clock edge GAP_CYC+1, counting the first post-reset edge as edge 1.
- xcvr_done/xcvr_err outside WAIT_RESP: ignored.

Test Plan:
Bench parameters: PERIOD_CYC=100, GAP_CYC=10, RESP_TO_CYC=50, MAX_RETRY=2.
- Good read. enable=1 from reset; start high after edge 11; xcvr_done 5 cycles later with frame=0x3700190050 -> two cycles after done, humidity=0x37, temperature=0x19, data_valid=1, update pulses once; next start 100+ cycles later.
- Checksum retry. Frame 0x3700190051 -> no update; retry start no earlier than 10 cycles after the previous start. Second frame 0x3700190050 -> update, err_cnt=0.
- Exhausted retries. Three consecutive xcvr_err pulses -> exactly 3 starts, err_cnt=1, data_valid=0, humidity/temperature hold prior values. Repeat 256 failed rounds -> err_cnt stays 255.
- Watchdog. No done/err after start -> FAIL 50 cycles after START; retry start follows.
- force_req. Pulse 3 cycles into POLL_WAIT -> start issued once gap_cnt reaches 10, not after 100. Pulse during WAIT_RESP -> no extra start.
- enable drop and reset. enable=0 during WAIT_RESP, then done with a good frame -> update occurs, then IDLE with no further starts. reset_n low mid-WAIT_RESP -> all outputs 0 immediately; the next start obeys the GAP_CYC+1 rule.
